// File: rtl/wbu_retire_queue_pkg.sv
// Shared types for the writeback retire queue: entry layout, field widths and the x0 index.
// Per-entry trace fields exist only when WBU_RETIRE_TRACE_EN is defined.
package wbu_retire_queue_pkg;

    localparam int unsigned ENTRY_XLEN = 32;
    localparam int unsigned REGS_DIG   = 5;
    localparam int unsigned CSR_DIG    = 12;

    localparam logic [REGS_DIG-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [REGS_DIG-1:0]   rd;
        logic [ENTRY_XLEN-1:0] result;
        logic                  reg_write;
        logic                  csr_write;
        logic [CSR_DIG-1:0]    csr_addr;
`ifdef WBU_RETIRE_TRACE_EN
        logic [31:0]           pc;
        logic [31:0]           inst;
        logic                  is_device;
`endif
    } wbu_entry_t;

endpackage

// File: rtl/wbu_fwd_match.sv
// Youngest-first forwarding match: candidate 0 is the youngest, candidate N-1 the oldest.
// A query of x0 never hits; a miss returns zero data.
module wbu_fwd_match
    import wbu_retire_queue_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic [RD_W-1:0] rs_i,
    input  logic            cand_valid_i [N],
    input  logic [RD_W-1:0] cand_rd_i    [N],
    input  logic [XLEN-1:0] cand_data_i  [N],
    output logic            hit_o,
    output logic [XLEN-1:0] data_o
);

    // Walk oldest to youngest so the last match written is the youngest one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (rs_i != RD_W'(REG_X0)) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (cand_valid_i[N-1-i] && (cand_rd_i[N-1-i] == rs_i)) begin
                    hit_o  = 1'b1;
                    data_o = cand_data_i[N-1-i];
                end
            end
        end
    end

endmodule

// File: rtl/wbu_retire_queue.sv
// In-order retire queue between LSU and the GPR/CSR write ports, with instret and forwarding.
// Optional per-entry pc/inst/is_device trace is enabled by defining WBU_RETIRE_TRACE_EN.
module wbu_retire_queue
    import wbu_retire_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REGS_DIG = 5,
    parameter int unsigned CSR_DIG  = 12,
    parameter int unsigned CNT_W    = 64
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [REGS_DIG-1:0]          in_rd,
    input  logic [XLEN-1:0]              in_result,
    input  logic                         in_reg_write,
    input  logic                         in_csr_write,
    input  logic [CSR_DIG-1:0]           in_csr_addr,
`ifdef WBU_RETIRE_TRACE_EN
    input  logic [31:0]                  in_pc,
    input  logic [31:0]                  in_inst,
    input  logic [0:0]                   in_is_device,
    output logic [31:0]                  retire_pc,
    output logic [31:0]                  retire_inst,
    output logic [0:0]                   retire_is_device,
`endif
    input  logic                         wb_stall,
    output logic                         rf_we,
    output logic [REGS_DIG-1:0]          rf_waddr,
    output logic [XLEN-1:0]              rf_wdata,
    output logic                         csr_we,
    output logic [CSR_DIG-1:0]           csr_waddr,
    output logic [XLEN-1:0]              csr_wdata,
    output logic                         retire_valid,
    output logic [CNT_W-1:0]             instret,
    input  logic [REGS_DIG-1:0]          fwd_rs,
    output logic                         fwd_hit,
    output logic [XLEN-1:0]              fwd_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
    localparam int unsigned E_XLEN = ENTRY_XLEN;
    localparam int unsigned E_RD_W = wbu_retire_queue_pkg::REGS_DIG;
    localparam int unsigned E_CS_W = wbu_retire_queue_pkg::CSR_DIG;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    wbu_entry_t         entry_q [DEPTH];
    wbu_entry_t         entry_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    wbu_entry_t         in_entry;
    wbu_entry_t         head_entry;
    logic               accept;

    logic               cand_valid [DEPTH+1];
    logic [REGS_DIG-1:0] cand_rd   [DEPTH+1];
    logic [XLEN-1:0]    cand_data  [DEPTH+1];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (DEPTH == 1) return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        in_entry           = '0;
        in_entry.rd        = E_RD_W'(in_rd);
        in_entry.result    = E_XLEN'(in_result);
        in_entry.reg_write = in_reg_write;
        in_entry.csr_write = in_csr_write;
        in_entry.csr_addr  = E_CS_W'(in_csr_addr);
`ifdef WBU_RETIRE_TRACE_EN
        in_entry.pc        = in_pc;
        in_entry.inst      = in_inst;
        in_entry.is_device = in_is_device[0];
`endif
    end

    assign head_entry   = entry_q[head_q];
    assign retire_valid = (count_q != '0) && !wb_stall;
    // Gated with reset_n so nothing is offered to LSU while the queue is held in reset.
    assign in_ready     = reset_n && ((count_q < DEPTH_C) || retire_valid);
    assign accept       = in_valid && in_ready;

    assign rf_we     = retire_valid && head_entry.reg_write && (head_entry.rd != REG_X0);
    assign rf_waddr  = REGS_DIG'(head_entry.rd);
    assign rf_wdata  = XLEN'(head_entry.result);
    assign csr_we    = retire_valid && head_entry.csr_write;
    assign csr_waddr = CSR_DIG'(head_entry.csr_addr);
    assign csr_wdata = XLEN'(head_entry.result);
    assign instret   = instret_q;
    assign occupancy = count_q;

`ifdef WBU_RETIRE_TRACE_EN
    assign retire_pc        = retire_valid ? head_entry.pc : '0;
    assign retire_inst      = retire_valid ? head_entry.inst : '0;
    assign retire_is_device = retire_valid ? head_entry.is_device : 1'b0;
`endif

    always_comb begin
        entry_d   = entry_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        instret_d = instret_q;
        if (accept) begin
            entry_d[tail_q] = in_entry;
            tail_d          = ptr_inc(tail_q);
        end
        if (retire_valid) begin
            head_d    = ptr_inc(head_q);
            instret_d = instret_q + 1'b1;
        end
        unique case ({accept, retire_valid})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry_q   <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            instret_q <= '0;
        end else begin
            entry_q   <= entry_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            instret_q <= instret_d;
        end
    end

    // Candidate 0 is the incoming beat; 1..DEPTH walk the queue from tail-1 back to head.
    always_comb begin
        logic [PTR_W-1:0] slot;
        wbu_entry_t       e;
        cand_valid[0] = reset_n && in_valid && in_reg_write;
        cand_rd[0]    = in_rd;
        cand_data[0]  = in_result;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = (DEPTH == 1) ? '0 : tail_q - PTR_W'(i + 1);
            e    = entry_q[slot];
            cand_valid[i+1] = (OCC_W'(i) < count_q) && e.reg_write;
            cand_rd[i+1]    = REGS_DIG'(e.rd);
            cand_data[i+1]  = XLEN'(e.result);
        end
    end

    wbu_fwd_match #(
        .N    (DEPTH + 1),
        .XLEN (XLEN),
        .RD_W (REGS_DIG)
    ) u_fwd_match (
        .rs_i         (fwd_rs),
        .cand_valid_i (cand_valid),
        .cand_rd_i    (cand_rd),
        .cand_data_i  (cand_data),
        .hit_o        (fwd_hit),
        .data_o       (fwd_data)
    );

endmodule

// File: tb/tb_wbu_retire_queue.sv
// Directed vector table plus a hand-written mid-operation reset sequence for wbu_retire_queue.
module tb_wbu_retire_queue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_reg_write;
    logic        in_csr_write;
    logic [11:0] in_csr_addr;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        retire_valid;
    logic [63:0] instret;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [1:0]  occupancy;

    int compared   = 0;
    int mismatched = 0;
    int cur_vec    = -1;

    always #5 clock = ~clock;

    wbu_retire_queue #(
        .DEPTH    (2),
        .XLEN     (32),
        .REGS_DIG (5),
        .CSR_DIG  (12),
        .CNT_W    (64)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_result    (in_result),
        .in_reg_write (in_reg_write),
        .in_csr_write (in_csr_write),
        .in_csr_addr  (in_csr_addr),
        .wb_stall     (wb_stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .csr_we       (csr_we),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .retire_valid (retire_valid),
        .instret      (instret),
        .fwd_rs       (fwd_rs),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
        .occupancy    (occupancy)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        rw;
        logic        cw;
        logic [11:0] ca;
        logic        st;
        logic [4:0]  frs;
        logic        e_rdy;
        logic        e_rv;
        logic        e_rfwe;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_cswe;
        logic [11:0] e_ca;
        logic [1:0]  e_occ;
        logic        e_hit;
        logic [31:0] e_fd;
        logic [63:0] e_ir;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s (vec %0d): got 0x%0h, want 0x%0h", nm, cur_vec, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] rd, input logic [31:0] res,
                         input logic rw, input logic cw, input logic [11:0] ca,
                         input logic st, input logic [4:0] frs);
        in_valid     = iv;
        in_rd        = rd;
        in_result    = res;
        in_reg_write = rw;
        in_csr_write = cw;
        in_csr_addr  = ca;
        wb_stall     = st;
        fwd_rs       = frs;
    endtask

    initial begin
        //              iv    rd     res            rw    cw    ca        st    frs      rdy   rv    rfwe  wa     wd             cswe  eca       occ   hit   fd             ir
        vecs[0]  = '{1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 12'h000, 1'b0, 5'd5,   1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd0, 1'b1, 32'h0000_1234, 64'd0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 12'h000, 1'b0, 5'd5,   1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 12'h000, 2'd1, 1'b1, 32'h0000_1234, 64'd0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 12'h000, 1'b1, 5'd5,   1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd0, 1'b0, 32'h0,         64'd1};
        vecs[3]  = '{1'b1, 5'd3, 32'h0000_000A, 1'b1, 1'b0, 12'h000, 1'b1, 5'd3,   1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd0, 1'b1, 32'h0000_000A, 64'd1};
        vecs[4]  = '{1'b1, 5'd3, 32'h0000_000B, 1'b1, 1'b0, 12'h000, 1'b1, 5'd3,   1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd1, 1'b1, 32'h0000_000B, 64'd1};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 12'h000, 1'b1, 5'd3,   1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd2, 1'b1, 32'h0000_000B, 64'd1};
        vecs[6]  = '{1'b1, 5'd3, 32'h0000_000C, 1'b1, 1'b0, 12'h000, 1'b1, 5'd3,   1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd2, 1'b1, 32'h0000_000C, 64'd1};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 12'h000, 1'b1, 5'd0,   1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd2, 1'b0, 32'h0,         64'd1};
        vecs[8]  = '{1'b1, 5'd9, 32'h0000_0099, 1'b1, 1'b0, 12'h000, 1'b0, 5'd9,   1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_000A, 1'b0, 12'h000, 2'd2, 1'b1, 32'h0000_0099, 64'd1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 12'h000, 1'b0, 5'd3,   1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_000B, 1'b0, 12'h000, 2'd2, 1'b1, 32'h0000_000B, 64'd2};
        vecs[10] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 12'h000, 1'b0, 5'd3,   1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 12'h000, 2'd1, 1'b0, 32'h0,         64'd3};
        vecs[11] = '{1'b1, 5'd7, 32'h8000_0000, 1'b1, 1'b1, 12'h341, 1'b0, 5'd7,   1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd0, 1'b1, 32'h8000_0000, 64'd4};
        vecs[12] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 12'h000, 1'b0, 5'd7,   1'b1, 1'b1, 1'b1, 5'd7, 32'h8000_0000, 1'b1, 12'h341, 2'd1, 1'b1, 32'h8000_0000, 64'd4};
        vecs[13] = '{1'b1, 5'd0, 32'h0000_0055, 1'b1, 1'b0, 12'h000, 1'b0, 5'd0,   1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd0, 1'b0, 32'h0,         64'd5};
        vecs[14] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 12'h000, 1'b0, 5'd0,   1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd1, 1'b0, 32'h0,         64'd5};
        vecs[15] = '{1'b1, 5'd4, 32'h0000_0066, 1'b0, 1'b0, 12'h000, 1'b0, 5'd4,   1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd0, 1'b0, 32'h0,         64'd6};
        vecs[16] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 12'h000, 1'b0, 5'd4,   1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd1, 1'b0, 32'h0,         64'd6};
        vecs[17] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 12'h000, 1'b0, 5'd4,   1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 12'h000, 2'd0, 1'b0, 32'h0,         64'd7};

        reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 12'h000, 1'b0, 5'd0);
        #12;
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_instret", instret, 64'd0);
        chk("reset_retire_valid", 64'(retire_valid), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            cur_vec = i;
            drive(vecs[i].iv, vecs[i].rd, vecs[i].res, vecs[i].rw, vecs[i].cw,
                  vecs[i].ca, vecs[i].st, vecs[i].frs);
            #1;
            chk("in_ready", 64'(in_ready), 64'(vecs[i].e_rdy));
            chk("retire_valid", 64'(retire_valid), 64'(vecs[i].e_rv));
            chk("rf_we", 64'(rf_we), 64'(vecs[i].e_rfwe));
            if (vecs[i].e_rfwe) begin
                chk("rf_waddr", 64'(rf_waddr), 64'(vecs[i].e_wa));
                chk("rf_wdata", 64'(rf_wdata), 64'(vecs[i].e_wd));
            end
            chk("csr_we", 64'(csr_we), 64'(vecs[i].e_cswe));
            if (vecs[i].e_cswe) begin
                chk("csr_waddr", 64'(csr_waddr), 64'(vecs[i].e_ca));
                chk("csr_wdata", 64'(csr_wdata), 64'(vecs[i].e_wd));
            end
            chk("occupancy", 64'(occupancy), 64'(vecs[i].e_occ));
            chk("fwd_hit", 64'(fwd_hit), 64'(vecs[i].e_hit));
            chk("fwd_data", 64'(fwd_data), 64'(vecs[i].e_fd));
            chk("instret", instret, vecs[i].e_ir);
        end

        // Fill the queue under stall, then pull reset between clock edges.
        cur_vec = 100;
        @(negedge clock);
        drive(1'b1, 5'd10, 32'h0000_0010, 1'b1, 1'b0, 12'h000, 1'b1, 5'd10);
        @(negedge clock);
        drive(1'b1, 5'd11, 32'h0000_0011, 1'b1, 1'b1, 12'h300, 1'b1, 5'd10);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 12'h000, 1'b1, 5'd10);
        #1;
        chk("prefill_occupancy", 64'(occupancy), 64'd2);
        chk("prefill_fwd_data", 64'(fwd_data), 64'h10);
        chk("prefill_instret", instret, 64'd7);
        #1;
        reset_n  = 1'b0;
        wb_stall = 1'b0;
        #1;
        chk("async_rst_occupancy", 64'(occupancy), 64'd0);
        chk("async_rst_retire_valid", 64'(retire_valid), 64'd0);
        chk("async_rst_rf_we", 64'(rf_we), 64'd0);
        chk("async_rst_csr_we", 64'(csr_we), 64'd0);
        chk("async_rst_instret", instret, 64'd0);
        chk("async_rst_fwd_hit", 64'(fwd_hit), 64'd0);
        chk("async_rst_fwd_data", 64'(fwd_data), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        #1;
        chk("rst_release_occupancy", 64'(occupancy), 64'd0);
        chk("rst_release_retire_valid", 64'(retire_valid), 64'd0);
        chk("rst_release_instret", instret, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wbu_retire_queue.md
Name: wbu_retire_queue

Overview:
- Parametrised successor to the single-cycle writeback stage: a DEPTH-entry in-order retire queue between LSU and the GPR/CSR register files.
- Accepts LSU results over a valid/ready handshake and buffers them while the writeback path is stalled.
- Retires one entry per cycle to one GPR write port and one CSR write port, counts retired instructions, and forwards the youngest matching pending result to decode/EXU.

Parameters:
- DEPTH, 2, queue entries; power of two, ≥1
- XLEN, 32, result width
- REGS_DIG, 5, GPR index width
- CSR_DIG, 12, CSR address width
- CNT_W, 64, retired-instruction counter width

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  LSU result valid
- in_ready  out  1  queue can accept
- in_rd  in  REGS_DIG  destination GPR
- in_result  in  XLEN  writeback data (GPR and CSR)
- in_reg_write  in  1  GPR write request
- in_csr_write  in  1  CSR write request
- in_csr_addr  in  CSR_DIG  CSR address
- wb_stall  in  1  register-file side cannot retire this cycle
- rf_we  out  1  GPR write enable
- rf_waddr  out  REGS_DIG  GPR write index
- rf_wdata  out  XLEN  GPR write data
- csr_we  out  1  CSR write enable
- csr_waddr  out  CSR_DIG  CSR write address
- csr_wdata  out  XLEN  CSR write data
- retire_valid  out  1  an entry retires this cycle
- instret  out  CNT_W  retired-instruction count
- fwd_rs  in  REGS_DIG  forwarding query index
- fwd_hit  out  1  pending write to fwd_rs exists
- fwd_data  out  XLEN  youngest pending value for fwd_rs
- occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Storage: circular buffer, head/tail pointers of $clog2(DEPTH) bits with natural wrap-around, plus a count register. Each entry holds rd, result, reg_write, csr_write, csr_addr.
- Reset (async, reset_n low): head=tail=count=0, instret=0, all entry flags cleared. Every output that depends on queue state goes to 0 combinationally. in_ready=1 once reset deasserts. Reset asserted mid-operation drops all pending entries with no write.
- Accept: in_valid && in_ready at the clock edge writes the entry at tail; tail increments.
- in_ready = (count < DEPTH) || retire_valid. When full and retiring, a simultaneous accept is allowed and count stays DEPTH.
- Retire: retire_valid = (count != 0) && !wb_stall. Write enables come from the head entry combinationally:
  - rf_we = retire_valid && reg_write && (rd != 0)
  - csr_we = retire_valid && csr_write
- An entry with both writes set (csrrw-type) retires both in the same cycle. An entry with neither write set still retires and counts.
- On retire the head increments and instret increments by 1, wrapping at 2^CNT_W.
- Latency: minimum 1 cycle from accept to retire; there is no empty bypass.
- Simultaneous accept and retire: count unchanged. Empty with stall: no retire, accept allowed. Full with stall: in_ready=0.
- Forwarding is combinational. Candidates are the incoming beat (in_valid && in_reg_write, youngest) and then valid queue entries from tail-1 back to head. Only entries with reg_write && rd != 0 match.
  - fwd_hit=1 with the youngest matching result.
  - fwd_rs==0 always gives fwd_hit=0 and fwd_data=0.
  - No match gives fwd_data=0.
- occupancy = count.

Optional Feature:
- Macro: WBU_RETIRE_TRACE_EN.
- When defined:
  - Extra inputs in_pc[31:0], in_inst[31:0] and in_is_device[0:0] are stored per entry.
  - Outputs retire_pc, retire_inst, retire_is_device reflect the head entry while retire_valid=1, and are 0 otherwise.
  - Used by difftest/trace.
- When undefined: these ports and storage do not exist, and timing and behaviour are otherwise identical.

Decomposition:
- Shared package: the entry struct typedef (rd, result, reg_write, csr_write, csr_addr, plus optional pc/inst/is_device), REGS_DIG/CSR_DIG constants, and the x0 index constant.
- One natural sub-module: wbu_fwd_match, the priority youngest-first match over the incoming beat and queue entries, producing hit and data.

Test Plan:
- Reset, then accept rd=5, result=0x1234, reg_write=1, wb_stall=0 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; instret=1.
- Hold wb_stall=1 and push DEPTH=2 entries → in_ready=0, occupancy=2. Release the stall while pushing a third entry in the same cycle → accepted, occupancy stays 2, entries retire in order.
- Queue holds rd=3 with 0xA, then rd=3 with 0xB, stalled; query fwd_rs=3 → hit, 0xB. Add incoming rd=3 with 0xC → 0xC. Query fwd_rs=0 → hit=0.
- csrrw-type entry: rd=7, csr_addr=0x341, result=0x80000000 → rf_we and csr_we both 1 in the same cycle, instret +1.
- Entry with rd=0, reg_write=1 → rf_we=0, retire_valid=1, instret increments.
- Assert reset_n=0 with 2 entries pending → occupancy=0, no writes, instret=0 immediately, with no clock edge required.
